// File: rtl/tim_sched_pkg.sv
// tim_sched_pkg: shared states, timer register offsets and channel count for the reload scheduler
package tim_sched_pkg;
  localparam int NCH = 2;
  localparam logic [7:0] LOAD0 = 8'h00;
  localparam logic [7:0] EOI0 = 8'h0C;
  localparam logic [7:0] LOAD1 = 8'h14;
  localparam logic [7:0] EOI1 = 8'h20;
  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, DONE} state_e;
endpackage

// File: rtl/tim_reload_sched_if.sv
// tim_reload_sched_if: APB link between the scheduler (master) and the timer port (slave)
interface tim_reload_sched_if #(parameter int ADDR_W = 8);
  logic m_psel;
  logic m_penable;
  logic m_pwrite;
  logic [ADDR_W-1:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;
  modport master(output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, input m_prdata);
  modport slave(input m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, output m_prdata);
endinterface

// File: rtl/tim_sched_rr_arb.sv
// tim_sched_rr_arb: 2-way round-robin arbiter, pointer holds the last served channel
module tim_sched_rr_arb (
  input  logic       pclk,
  input  logic       presetn,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_ch,
  output logic       gnt_vld,
  output logic       gnt_ch
);
  logic last_q, last_d;
  always_comb begin
    gnt_vld = |req;
    gnt_ch = &req ? ~last_q : req[1];
    last_d = upd ? upd_ch : last_q;
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/tim_reload_sched.sv
// tim_reload_sched: services timer interrupts by writing the pending reload value then reading EOI over APB
module tim_reload_sched import tim_sched_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int GUARD_CYC = 2
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            ctrl_en,
  input  logic [NCH-1:0]  tim_intr,
  input  logic [NCH-1:0]  rld_wr,
  input  logic [31:0]     rld_data,
  output logic [NCH-1:0]  rld_full,
  output logic [NCH-1:0]  svc_done,
  output logic [NCH-1:0]  underrun,
  output logic            busy,
  tim_reload_sched_if.master m
);
  localparam int GW = $clog2(GUARD_CYC + 2);
  state_e state_q, state_d;
  logic ch_q, ch_d;
  logic [NCH-1:0] full_q, full_d, und_q, und_d, req;
  logic [31:0] slot_q [NCH];
  logic [31:0] slot_d [NCH];
  logic [31:0] pwdata_q, pwdata_d;
  logic [GW-1:0] guard_q [NCH];
  logic [GW-1:0] guard_d [NCH];
  logic gnt_vld, gnt_ch, wr_ph, rd_ph;
  always_comb
    for (int n = 0; n < NCH; n++) req[n] = ctrl_en & tim_intr[n] & (guard_q[n] == '0);
  tim_sched_rr_arb u_arb (
    .pclk   (pclk),
    .presetn(presetn),
    .req    (req),
    .upd    (state_q == DONE),
    .upd_ch (ch_q),
    .gnt_vld(gnt_vld),
    .gnt_ch (gnt_ch)
  );
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    full_d = full_q;
    und_d = und_q;
    pwdata_d = pwdata_q;
    for (int n = 0; n < NCH; n++) begin
      slot_d[n] = slot_q[n];
      guard_d[n] = (guard_q[n] != '0) ? guard_q[n] - 1'b1 : '0;
    end
    case (state_q)
      IDLE:
        if (gnt_vld) begin
          ch_d = gnt_ch;
          state_d = full_q[gnt_ch] ? WR_SETUP : RD_SETUP;
          und_d[gnt_ch] = und_q[gnt_ch] | ~full_q[gnt_ch];
        end
      WR_SETUP: begin
        state_d = WR_ACCESS;
        full_d[ch_q] = 1'b0;
        pwdata_d = slot_q[ch_q];
      end
      WR_ACCESS: state_d = RD_SETUP;
      RD_SETUP: state_d = RD_ACCESS;
      RD_ACCESS: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        guard_d[ch_q] = GW'(GUARD_CYC);
      end
      default: state_d = IDLE;
    endcase
    // applied last so a producer write landing on the consume cycle keeps the slot full
    for (int n = 0; n < NCH; n++)
      if (rld_wr[n]) begin
        slot_d[n] = rld_data;
        full_d[n] = 1'b1;
      end
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state_q <= IDLE;
      ch_q <= 1'b0;
      full_q <= '0;
      und_q <= '0;
      pwdata_q <= '0;
      for (int n = 0; n < NCH; n++) begin
        slot_q[n] <= '0;
        guard_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      full_q <= full_d;
      und_q <= und_d;
      pwdata_q <= pwdata_d;
      slot_q <= slot_d;
      guard_q <= guard_d;
    end
  always_comb begin
    wr_ph = (state_q == WR_SETUP) || (state_q == WR_ACCESS);
    rd_ph = (state_q == RD_SETUP) || (state_q == RD_ACCESS);
  end
  assign m.m_psel = wr_ph | rd_ph;
  assign m.m_penable = (state_q == WR_ACCESS) || (state_q == RD_ACCESS);
  assign m.m_pwrite = wr_ph;
  assign m.m_paddr = wr_ph ? ADDR_W'(ch_q ? LOAD1 : LOAD0) : rd_ph ? ADDR_W'(ch_q ? EOI1 : EOI0) : '0;
  assign m.m_pwdata = (state_q == WR_SETUP) ? slot_q[ch_q] : (state_q == WR_ACCESS) ? pwdata_q : '0;
  assign svc_done = {(state_q == DONE) & ch_q, (state_q == DONE) & ~ch_q};
  assign underrun = und_q;
  assign rld_full = full_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_tim_reload_sched.sv
// tb_tim_reload_sched: vector table plus corner sequences, APB traffic checked against a scoreboard queue
module tb_tim_reload_sched;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic ctrl_en = 1'b0;
  logic [1:0] tim_intr = '0;
  logic [1:0] rld_wr = '0;
  logic [31:0] rld_data = '0;
  logic [1:0] rld_full, svc_done, underrun;
  logic busy;
  int n_chk = 0;
  int n_fail = 0;
  tim_reload_sched_if #(.ADDR_W(8)) m ();
  assign m.m_prdata = 32'hFEED_0001;
  tim_reload_sched #(.ADDR_W(8), .GUARD_CYC(2)) dut (
    .pclk(pclk), .presetn(presetn), .ctrl_en(ctrl_en), .tim_intr(tim_intr),
    .rld_wr(rld_wr), .rld_data(rld_data), .rld_full(rld_full), .svc_done(svc_done),
    .underrun(underrun), .busy(busy), .m(m)
  );
  always #5 pclk = ~pclk;
  typedef struct packed {logic w; logic [7:0] a; logic [31:0] d;} txn_t;
  txn_t sb[$];
  // cyc: cycles from the grant cycle to the svc_done pulse, 0 = no service expected
  typedef struct packed {
    logic en; logic [1:0] wr; logic [31:0] data; logic [1:0] intr;
    logic ch; int cyc; logic [31:0] wd; logic [1:0] full; logic [1:0] und;
  } vec_t;
  vec_t vt [9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
    txn_t t;
    t.w = w; t.a = a; t.d = d;
    sb.push_back(t);
  endtask
  task automatic wait_done(output logic [1:0] sd, output int cyc);
    sd = '0;
    cyc = 0;
    while (sd == '0 && cyc < 40) begin
      @(negedge pclk);
      cyc++;
      sd = svc_done;
    end
  endtask
  task automatic load(input logic [1:0] wr, input logic [31:0] d);
    @(negedge pclk);
    rld_wr = wr;
    rld_data = d;
    @(negedge pclk);
    rld_wr = '0;
  endtask
  task automatic settle();
    tim_intr = '0;
    repeat (3) @(negedge pclk);
  endtask
  always @(negedge pclk)
    if (presetn && m.m_psel && m.m_penable) begin
      if (sb.size() == 0) chk("apb_unexpected", {m.m_pwrite, m.m_paddr}, 0);
      else begin
        txn_t t;
        t = sb.pop_front();
        chk("apb_pwrite", m.m_pwrite, t.w);
        chk("apb_paddr", m.m_paddr, t.a);
        if (t.w) chk("apb_pwdata", m.m_pwdata, t.d);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] sd;
    int cyc, cnt;
    vt[0] = '{1'b1, 2'b01, 32'h0000_1000, 2'b01, 1'b0, 5, 32'h0000_1000, 2'b00, 2'b00};
    vt[1] = '{1'b1, 2'b00, 32'h0, 2'b10, 1'b1, 3, 32'h0, 2'b00, 2'b10};
    vt[2] = '{1'b1, 2'b10, 32'hDEAD_BEEF, 2'b10, 1'b1, 5, 32'hDEAD_BEEF, 2'b00, 2'b10};
    vt[3] = '{1'b1, 2'b00, 32'h0, 2'b01, 1'b0, 3, 32'h0, 2'b00, 2'b11};
    vt[4] = '{1'b1, 2'b11, 32'h1234_5678, 2'b01, 1'b0, 5, 32'h1234_5678, 2'b10, 2'b11};
    vt[5] = '{1'b1, 2'b00, 32'h0, 2'b10, 1'b1, 5, 32'h1234_5678, 2'b00, 2'b11};
    vt[6] = '{1'b0, 2'b01, 32'h0000_0007, 2'b01, 1'b0, 0, 32'h0, 2'b01, 2'b11};
    vt[7] = '{1'b1, 2'b00, 32'h0, 2'b01, 1'b0, 5, 32'h0000_0007, 2'b00, 2'b11};
    vt[8] = '{1'b1, 2'b10, 32'h0BAD_F00D, 2'b10, 1'b1, 5, 32'h0BAD_F00D, 2'b00, 2'b11};
    #12;
    chk("rst_psel", m.m_psel, 0);
    chk("rst_penable", m.m_penable, 0);
    chk("rst_paddr", m.m_paddr, 0);
    chk("rst_pwdata", m.m_pwdata, 0);
    chk("rst_outs", {rld_full, underrun, svc_done, busy}, 0);
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ctrl_en = vt[i].en;
      if (vt[i].wr != '0) load(vt[i].wr, vt[i].data);
      if (vt[i].cyc == 5) push(1'b1, vt[i].ch ? 8'h14 : 8'h00, vt[i].wd);
      if (vt[i].cyc != 0) push(1'b0, vt[i].ch ? 8'h20 : 8'h0C, 32'h0);
      tim_intr = vt[i].intr;
      if (vt[i].cyc == 0) begin
        cnt = 0;
        repeat (8) begin
          @(negedge pclk);
          cnt += int'(busy) + int'(svc_done != '0);
        end
        chk($sformatf("vec%0d_idle", i), cnt, 0);
      end else begin
        wait_done(sd, cyc);
        chk($sformatf("vec%0d_done", i), sd, vt[i].ch ? 2'b10 : 2'b01);
        chk($sformatf("vec%0d_lat", i), cyc, vt[i].cyc);
      end
      tim_intr = '0;
      @(negedge pclk);
      chk($sformatf("vec%0d_full", i), rld_full, vt[i].full);
      chk($sformatf("vec%0d_und", i), underrun, vt[i].und);
      settle();
    end
    load(2'b01, 32'hA0);
    load(2'b10, 32'hB1);
    push(1'b1, 8'h00, 32'hA0); push(1'b0, 8'h0C, 0);
    push(1'b1, 8'h14, 32'hB1); push(1'b0, 8'h20, 0);
    tim_intr = 2'b11;
    wait_done(sd, cyc);
    chk("tie_first", sd, 2'b01);
    chk("tie_first_lat", cyc, 5);
    wait_done(sd, cyc);
    chk("tie_second", sd, 2'b10);
    chk("b2b_gap", cyc, 6);
    settle();
    push(1'b0, 8'h0C, 0); push(1'b0, 8'h20, 0);
    tim_intr = 2'b11;
    wait_done(sd, cyc);
    chk("tie_again", sd, 2'b01);
    chk("tie_again_lat", cyc, 3);
    wait_done(sd, cyc);
    chk("tie_again_second", {sd, 8'(cyc)}, {2'b10, 8'd4});
    settle();
    load(2'b01, 32'h600D);
    push(1'b1, 8'h00, 32'h600D); push(1'b0, 8'h0C, 0);
    tim_intr = 2'b01;
    wait_done(sd, cyc);
    chk("guard_svc", {sd, 8'(cyc)}, {2'b01, 8'd5});
    @(negedge pclk);
    chk("guard_idle1", busy, 0);
    @(negedge pclk);
    chk("guard_idle2", busy, 0);
    tim_intr = '0;
    cnt = 0;
    repeat (4) begin
      @(negedge pclk);
      cnt += int'(busy);
    end
    chk("guard_no_resvc", cnt, 0);
    push(1'b0, 8'h0C, 0); push(1'b0, 8'h0C, 0);
    tim_intr = 2'b01;
    wait_done(sd, cyc);
    chk("persist_first", {sd, 8'(cyc)}, {2'b01, 8'd3});
    wait_done(sd, cyc);
    chk("persist_resvc", sd, 2'b01);
    chk("persist_resvc_lat", cyc, 6);
    settle();
    load(2'b01, 32'hA);
    push(1'b1, 8'h00, 32'hA); push(1'b0, 8'h0C, 0);
    tim_intr = 2'b01;
    @(negedge pclk);
    rld_wr = 2'b01;
    rld_data = 32'hB;
    chk("coll_setup_wdata", m.m_pwdata, 32'hA);
    @(negedge pclk);
    rld_wr = '0;
    chk("coll_full", rld_full[0], 1'b1);
    wait_done(sd, cyc);
    chk("coll_done", {sd, 8'(cyc)}, {2'b01, 8'd3});
    settle();
    push(1'b1, 8'h00, 32'hB); push(1'b0, 8'h0C, 0);
    tim_intr = 2'b01;
    wait_done(sd, cyc);
    chk("coll_new_val", {sd, 8'(cyc)}, {2'b01, 8'd5});
    settle();
    chk("coll_full_after", rld_full, 2'b00);
    push(1'b0, 8'h20, 0);
    tim_intr = 2'b10;
    @(negedge pclk);
    ctrl_en = 1'b0;
    wait_done(sd, cyc);
    chk("dis_completes", {sd, 8'(cyc)}, {2'b10, 8'd2});
    cnt = 0;
    repeat (8) begin
      @(negedge pclk);
      cnt += int'(busy);
    end
    chk("dis_no_grant", cnt, 0);
    push(1'b0, 8'h20, 0);
    ctrl_en = 1'b1;
    wait_done(sd, cyc);
    chk("reen_svc", {sd, 8'(cyc)}, {2'b10, 8'd3});
    settle();
    load(2'b01, 32'hC);
    tim_intr = 2'b01;
    @(posedge pclk);
    @(posedge pclk);
    #1;
    presetn = 1'b0;
    #1;
    chk("arst_bus", {m.m_psel, m.m_penable}, 2'b00);
    chk("arst_state", {busy, rld_full, underrun}, 0);
    @(negedge pclk);
    push(1'b0, 8'h0C, 0);
    presetn = 1'b1;
    wait_done(sd, cyc);
    chk("arst_resvc", {sd, 8'(cyc)}, {2'b01, 8'd3});
    tim_intr = '0;
    @(negedge pclk);
    chk("arst_und", underrun, 2'b01);
    repeat (5) @(negedge pclk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
